rc5_key_loader: RTL

Parametrised, single-clock successor to the key-bytes-to-words stage of the RC5 key expansion. On a `start` pulse it fetches the `b` secret-key bytes from an external synchronous byte memory, packs them into `c` words of `w` bits (array L), and holds L in an internal register file readable by the mixing stage. Word width, key length and byte order are configurable, and it supports zero-length and non-word-multiple keys with zero fill.

---
 rtl/rc5_key_loader_if.sv | 43 ++++
 rtl/rc5_key_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rc5_key_loader_if.sv
// ============================================================================
//  Module      : rc5_key_loader_if
//  Description : Bundle for the RC5 key loader. It carries the load handshake,
//                the key byte memory read port and the L register file read
//                port.
//                  start       request to load a new key
//                  busy / done load in progress / L valid and complete
//                  key_rd, key_address, key_sub_i   synchronous key memory
//                  L_address, L_sub_i               L word read port
//                Modport master is the loader side. Modport slave is the
//                surrounding system: key memory, controller and mixing stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rc5_key_loader_if #(
  parameter int w        = 32,
  parameter int b        = 16,
  parameter int b_length = ($clog2(b) < 1) ? 1 : $clog2(b),
  parameter int c_length = ($clog2((b == 0) ? 1 : (b + w/8 - 1) / (w/8)) < 1) ? 1
                           : $clog2((b == 0) ? 1 : (b + w/8 - 1) / (w/8))
);
  logic                start;
  logic                busy;
  logic                done;
  logic                key_rd;
  logic [b_length-1:0] key_address;
  logic [7:0]          key_sub_i;
  logic [c_length-1:0] L_address;
  logic [w-1:0]        L_sub_i;

  modport master (
    input  start, key_sub_i, L_address,
    output key_rd, key_address, L_sub_i, busy, done
  );

  modport slave (
    output start, key_sub_i, L_address,
    input  key_rd, key_address, L_sub_i, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/rc5_key_loader.sv
// ============================================================================
//  Module      : rc5_key_loader
//  Description : RC5 key-bytes-to-words stage. A start pulse fetches the b key
//                bytes from an external synchronous byte memory, one read per
//                cycle. The bytes are packed into c = max(1, ceil(b/u)) words
//                of w bits (array L), which are held for the mixing stage.
//                Ports:
//                  clk1  sole clock, rising edge
//                  rst   asynchronous active-high reset
//                  bus   rc5_key_loader_if.master. It carries start, busy,
//                        done, the key memory read port (key_rd, key_address,
//                        key_sub_i) and the L read port (L_address, L_sub_i).
//                Optional feature, selected with the macro KEY_BYTE_ORDER_BE_EN:
//                  undefined : RC5 little-endian packing, addresses b-1 down to 0
//                  defined   : big-endian packing, addresses 0 up to b-1, and a
//                              partial final word is left-aligned
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rc5_key_loader #(
  parameter int w        = 32,
  parameter int b        = 16,
  parameter int b_length = ($clog2(b) < 1) ? 1 : $clog2(b),
  parameter int c_length = ($clog2((b == 0) ? 1 : (b + w/8 - 1) / (w/8)) < 1) ? 1
                           : $clog2((b == 0) ? 1 : (b + w/8 - 1) / (w/8))
) (
  input  logic             clk1,
  input  logic             rst,
  rc5_key_loader_if.master bus
);

  localparam int u     = w / 8;
  localparam int c     = (b == 0) ? 1 : (b + u - 1) / u;
  localparam int ub    = $clog2(u);
  // The consumed byte index splits exactly into {word select, byte position}.
  // ceil(b/u) words always cover b bytes, so this is never narrower than
  // key_address.
  localparam int idx_w = ub + c_length;
  localparam int depth = 1 << c_length;

  localparam logic [b_length-1:0] addr_max = (b == 0) ? '0 : b_length'(b - 1);
`ifdef KEY_BYTE_ORDER_BE_EN
  localparam logic [b_length-1:0] first_addr = '0;
  localparam logic [b_length-1:0] end_addr   = addr_max;
  localparam logic [idx_w-1:0]    idx_last   = idx_w'(addr_max);
`else
  localparam logic [b_length-1:0] first_addr = addr_max;
  localparam logic [b_length-1:0] end_addr   = '0;
`endif
  localparam logic [c_length:0]   c_lim      = (c_length + 1)'(c);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [w-1:0]        acc;
  logic                vld;       // key_sub_i carries a byte this cycle
  logic [idx_w-1:0]    idx;       // key index of the byte on key_sub_i
  logic [w-1:0]        l_mem [depth];

  logic [w-1:0]        next_acc;
  logic [w-1:0]        wr_data;
  logic                wr_en;
  logic [ub-1:0]       byte_pos;
  logic [c_length-1:0] word_sel;

  always_comb begin
    next_acc = (acc << 8) | w'(bus.key_sub_i);
    byte_pos = idx[ub-1:0];
    word_sel = idx[idx_w-1:ub];
`ifdef KEY_BYTE_ORDER_BE_EN
    // Ascending addresses: a word closes on its last byte or on the final key
    // byte. A short final word is shifted up so that its low bytes are zero.
    wr_en    = (byte_pos == ub'(u - 1)) || (idx == idx_last);
    wr_data  = next_acc << {ub'(u - 1) - byte_pos, 3'b000};
`else
    // Descending addresses: byte 0 of each word arrives last. A short top word
    // closes early and so holds zeros in its upper bytes.
    wr_en    = (byte_pos == '0);
    wr_data  = next_acc;
`endif
  end

  assign bus.L_sub_i = ({1'b0, bus.L_address} < c_lim) ? l_mem[bus.L_address] : '0;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.key_rd      <= 1'b0;
      bus.key_address <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      acc             <= '0;
      vld             <= 1'b0;
      idx             <= '0;
      for (int j = 0; j < depth; j++) l_mem[j] <= '0;
    end else begin
      // Data path runs one cycle behind the address: the memory returns the
      // byte for this cycle's address on the next cycle.
      vld <= bus.key_rd;
      idx <= idx_w'(bus.key_address);
      if (vld) begin
        if (wr_en) begin
          l_mem[word_sel] <= wr_data;
          acc             <= '0;
        end else begin
          acc <= next_acc;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            acc      <= '0;
            bus.done <= 1'b0;
            bus.busy <= 1'b1;
            if (b == 0) begin
              state <= DRAIN;
            end else begin
              state           <= FETCH;
              bus.key_rd      <= 1'b1;
              bus.key_address <= first_addr;
            end
          end
        end
        FETCH: begin
          if (bus.key_address == end_addr) begin
            bus.key_rd <= 1'b0;
            state      <= DRAIN;
          end else begin
`ifdef KEY_BYTE_ORDER_BE_EN
            bus.key_address <= bus.key_address + 1'b1;
`else
            bus.key_address <= bus.key_address - 1'b1;
`endif
          end
        end
        DRAIN: begin
          if (b == 0) l_mem[0] <= '0;
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
